// File: rtl/hub75_pkg.sv
// Shared HUB75 definitions: scan states, default panel geometry and a width helper
// used by the scan sequencer and the other panel-side modules.
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    FLUSH,
    LATCH,
    SHOW
  } state_t;

  localparam int DEF_COLS = 64;
  localparam int DEF_ROWS = 32;
  localparam int DEF_BITS = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Never returns zero so it can size a vector for a single-valued range.
  function automatic int width_of(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/bcm_ontime.sv
// Registered multiply-shift giving the SHOW period of a bitplane and the portion
// of it during which the panel is unblanked for the given global brightness.
module bcm_ontime
  import hub75_pkg::*;
#(
  parameter int BITS      = DEF_BITS,
  parameter int SHOW_UNIT = 16,
  parameter int PL_W      = width_of(BITS),
  parameter int CNT_W     = clog2(SHOW_UNIT) + BITS
) (
  input  logic             clk,
  input  logic             load,
  input  logic [PL_W-1:0]  plane,
  input  logic [7:0]       brightness,
  output logic [CNT_W-1:0] period_p1,
  output logic [CNT_W-1:0] on_p1
);

  localparam int PROD_W = 8 + CNT_W;

  // Full-precision product, truncated back to a cycle count (floor of duty/256).
  function automatic logic [CNT_W-1:0] scale_on(input logic [7:0]       duty,
                                                input logic [CNT_W-1:0] period);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(duty) * PROD_W'(period);
    return prod[PROD_W-1:8];
  endfunction

  logic [CNT_W-1:0] period_p0;

  assign period_p0 = CNT_W'(SHOW_UNIT) << plane;

  // p0 -> p1
  always_ff @(posedge clk) begin
    if (load) begin
      period_p1 <= period_p0;
      on_p1     <= scale_on(brightness, period_p0);
    end
  end

endmodule

// File: rtl/hub75_bcm_sequencer.sv
// HUB75 scan controller: walks rows and bitplanes, shifting one row per plane and
// showing it for a binary-weighted period gated by the global brightness.
module hub75_bcm_sequencer
  import hub75_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS      = DEF_ROWS,
  parameter int BITS      = DEF_BITS,
  parameter int SHOW_UNIT = 16,
  parameter int AX_W      = 8,
  parameter int AY_W      = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [7:0]                brightness,
  output logic [AX_W-1:0]           addrx,
  output logic [AY_W-1:0]           addry,
  output logic [width_of(BITS)-1:0] plane,
  output logic                      rd_en,
  output logic                      sclk_en,
  output logic                      latch,
  output logic                      blank,
  output logic                      frame_start,
  output logic                      busy
);

  localparam int PL_W  = width_of(BITS);
  localparam int CNT_W = clog2(SHOW_UNIT) + BITS;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_p1, on_p1;
  logic [AX_W-1:0]  addrx_d;
  logic [AY_W-1:0]  addry_d;
  logic [PL_W-1:0]  plane_d;
  logic             rd_en_d, sclk_en_d, latch_d, blank_d, frame_start_d, busy_d;
  logic             show_done, last_plane, last_row;

  assign show_done  = (cnt_q == period_p1 - CNT_W'(1));
  assign last_plane = (plane == PL_W'(BITS - 1));
  assign last_row   = (addry == AY_W'(ROWS - 1));

  // Brightness is captured as the row enters LATCH, so ON is settled before SHOW.
  bcm_ontime #(
    .BITS      (BITS),
    .SHOW_UNIT (SHOW_UNIT),
    .PL_W      (PL_W),
    .CNT_W     (CNT_W)
  ) u_ontime (
    .clk        (clk),
    .load       (state_q == FLUSH),
    .plane      (plane),
    .brightness (brightness),
    .period_p1  (period_p1),
    .on_p1      (on_p1)
  );

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    if (reset) begin
      state_q     <= IDLE;
      addrx       <= '0;
      addry       <= '0;
      plane       <= '0;
      rd_en       <= 1'b0;
      sclk_en     <= 1'b0;
      latch       <= 1'b0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      addrx       <= addrx_d;
      addry       <= addry_d;
      plane       <= plane_d;
      rd_en       <= rd_en_d;
      sclk_en     <= sclk_en_d;
      latch       <= latch_d;
      blank       <= blank_d;
      frame_start <= frame_start_d;
      busy        <= busy_d;
    end
  end

  // A frame only ends after its last row; enable is not looked at mid-frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = SHIFT;
      SHIFT:   if (addrx == AX_W'(COLS - 1)) state_d = FLUSH;
      FLUSH:   state_d = LATCH;
      LATCH:   state_d = SHOW;
      SHOW:    if (show_done) state_d = (last_plane && last_row && !enable) ? IDLE : SHIFT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addrx_d = '0;
    addry_d = addry;
    plane_d = plane;
    cnt_d   = '0;
    if (state_q == SHIFT && state_d == SHIFT) addrx_d = addrx + AX_W'(1);
    if (state_q == SHOW && state_d == SHOW) cnt_d = cnt_q + CNT_W'(1);
    if (state_q == IDLE) begin
      addry_d = '0;
      plane_d = '0;
    end else if (state_q == SHOW && state_d != SHOW) begin
      if (!last_plane) begin
        plane_d = plane + PL_W'(1);
      end else begin
        plane_d = '0;
        addry_d = last_row ? '0 : addry + AY_W'(1);
      end
    end
    rd_en_d       = (state_d == SHIFT);
    sclk_en_d     = rd_en;
    latch_d       = (state_d == LATCH);
    busy_d        = (state_d != IDLE);
    blank_d       = !(state_d == SHOW && cnt_d < on_p1);
    frame_start_d = (state_d == SHIFT) && (state_q != SHIFT) &&
                    (plane_d == '0) && (addry_d == '0);
  end

endmodule

// File: tb/tb_hub75_bcm_sequencer.sv
// Bench for hub75_bcm_sequencer on a tiny 4x2 panel with 2 bitplanes.
module tb_hub75_bcm_sequencer;

  localparam int COLS      = 4;
  localparam int ROWS      = 2;
  localparam int BITS      = 2;
  localparam int SHOW_UNIT = 4;
  localparam int AX_W      = 8;
  localparam int AY_W      = 5;
  localparam int PL_W      = 1;
  localparam int ROW_LEN   = BITS * (COLS + 2) + SHOW_UNIT * ((1 << BITS) - 1);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic [7:0]      brightness = 8'd0;
  logic [AX_W-1:0] addrx;
  logic [AY_W-1:0] addry;
  logic [PL_W-1:0] plane;
  logic            rd_en, sclk_en, latch, blank, frame_start, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hub75_bcm_sequencer #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .BITS      (BITS),
    .SHOW_UNIT (SHOW_UNIT),
    .AX_W      (AX_W),
    .AY_W      (AY_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .brightness  (brightness),
    .addrx       (addrx),
    .addry       (addry),
    .plane       (plane),
    .rd_en       (rd_en),
    .sclk_en     (sclk_en),
    .latch       (latch),
    .blank       (blank),
    .frame_start (frame_start),
    .busy        (busy)
  );

  // Reference: each plane of each row is COLS shift cycles, one flush, one latch,
  // then SHOW_UNIT<<p show cycles of which floor(b*P/256) are unblanked.
  task automatic play_frames(input int nframes, input int random_bright, input logic [7:0] b0);
    int per, on_t, total, fs_first, fs_second, fs_cnt;
    logic [5:0] got, exp;
    int e_ax, k;
    brightness = b0;
    enable = 1'b1;
    fs_first = -1;
    fs_second = -1;
    fs_cnt = 0;
    for (int f = 0; f < nframes; f++) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int p = 0; p < BITS; p++) begin
          per = SHOW_UNIT << p;
          on_t = (int'(brightness) * per) >> 8;
          total = COLS + 2 + per;
          for (int i = 0; i < total; i++) begin
            @(posedge clk); #1;
            k = i - (COLS + 2);
            e_ax = (i < COLS) ? i : 0;
            exp = {i < COLS, (i >= 1 && i <= COLS), i == COLS + 1,
                   !(k >= 0 && k < on_t), (i == 0 && r == 0 && p == 0), 1'b1};
            got = {rd_en, sclk_en, latch, blank, frame_start, busy};
            checks++;
            if (got !== exp || addrx !== AX_W'(e_ax) || addry !== AY_W'(r) || plane !== PL_W'(p)) begin
              errors++;
              $display("FAIL scan f%0d r%0d p%0d i%0d: got rd/sclk/lat/blk/fs/busy=%b x=%0d y=%0d pl=%0d, want %b x=%0d y=%0d pl=%0d",
                       f, r, p, i, got, addrx, addry, plane, exp, e_ax, r, p);
            end
            if (frame_start === 1'b1) begin
              fs_cnt++;
              if (fs_first < 0) fs_first = cyc;
              else if (fs_second < 0) fs_second = cyc;
            end
            if (random_bright != 0 && k == 1) brightness = 8'($urandom_range(0, 255));
            if (f == nframes - 1 && r == 0 && p == 0 && k == 0) enable = 1'b0;
          end
        end
      end
    end
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      got = {rd_en, sclk_en, latch, blank, frame_start, busy};
      checks++;
      if (got !== 6'b000100 || addry !== '0 || plane !== '0) begin
        errors++;
        $display("FAIL idle_after_frame j%0d: got %b y=%0d pl=%0d, want 000100 y=0 pl=0", j, got, addry, plane);
      end
    end
    checks++;
    if (fs_cnt != nframes) begin
      errors++;
      $display("FAIL frame_start_count: got %0d, want %0d", fs_cnt, nframes);
    end
    if (nframes > 1) begin
      checks++;
      if (fs_second - fs_first != ROWS * ROW_LEN) begin
        errors++;
        $display("FAIL frame_start_spacing: got %0d, want %0d", fs_second - fs_first, ROWS * ROW_LEN);
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] got;
    reset = 1'b1;
    enable = 1'b0;
    brightness = 8'd255;
    repeat (3) @(posedge clk);
    #1;
    got = {rd_en, sclk_en, latch, blank, frame_start, busy};
    checks++;
    if (got !== 6'b000100 || addrx !== '0 || addry !== '0 || plane !== '0) begin
      errors++;
      $display("FAIL reset_values: got %b x=%0d y=%0d pl=%0d, want 000100 x=0 y=0 pl=0", got, addrx, addry, plane);
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = {rd_en, sclk_en, latch, blank, frame_start, busy};
    checks++;
    if (got !== 6'b000100) begin
      errors++;
      $display("FAIL idle_without_enable: got %b, want 000100", got);
    end
  endtask

  task automatic test_full_brightness();
    play_frames(2, 0, 8'd255);
  endtask

  task automatic test_half_brightness();
    play_frames(1, 0, 8'd128);
  endtask

  task automatic test_dark();
    play_frames(1, 0, 8'd0);
  endtask

  task automatic test_brightness_change();
    play_frames(3, 1, 8'($urandom_range(0, 255)));
  endtask

  // Sample 0 is the first SHIFT cycle; row 1 plane 1 LATCH falls on sample 39, SHOW on 40..47.
  task automatic test_reset_mid(input int at);
    logic [5:0] got;
    logic       want_latch;
    enable = 1'b1;
    brightness = 8'd200;
    for (int k = 0; k <= at; k++) begin
      @(posedge clk); #1;
    end
    want_latch = (at == COLS + 1 + ROW_LEN + COLS + 2 + SHOW_UNIT);
    checks++;
    if (latch !== want_latch || rd_en !== 1'b0 || busy !== 1'b1 || addry !== AY_W'(1) || plane !== PL_W'(1)) begin
      errors++;
      $display("FAIL pre_reset_position at%0d: got lat=%b rd=%b busy=%b y=%0d pl=%0d, want lat=%b rd=0 busy=1 y=1 pl=1",
               at, latch, rd_en, busy, addry, plane, want_latch);
    end
    reset = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;
    got = {rd_en, sclk_en, latch, blank, frame_start, busy};
    checks++;
    if (got !== 6'b000100 || addrx !== '0 || addry !== '0 || plane !== '0) begin
      errors++;
      $display("FAIL reset_mid at%0d: got %b x=%0d y=%0d pl=%0d, want 000100 x=0 y=0 pl=0", at, got, addrx, addry, plane);
    end
    reset = 1'b0;
    play_frames(1, 0, 8'd128);
  endtask

  initial begin
    test_reset();
    test_full_brightness();
    test_half_brightness();
    test_dark();
    test_brightness_change();
    test_reset_mid(42);
    test_reset_mid(39);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
